// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: imem port, redirect, and decode handshake
interface fetch_unit_if;
    logic       en;
    logic [7:0] imem_addr;
    logic [7:0] imem_instr;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic [7:0] instr_out;
    logic [7:0] pc_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       halted;

    modport master (
        input  en, imem_instr, branch_valid, branch_target, instr_ready,
        output imem_addr, instr_out, pc_out, instr_valid, halted
    );

    modport slave (
        output en, imem_instr, branch_valid, branch_target, instr_ready,
        input  imem_addr, instr_out, pc_out, instr_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-slot instruction fetch with redirect, halt and decode backpressure
module fetch_unit #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter logic [7:0] HALT_INSTR = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt;
    logic [7:0] instr_q, instr_nxt;
    logic [7:0] pcq, pcq_nxt;
    logic       valid, valid_nxt;
    logic       transfer, slot_free;

    assign transfer  = valid & bus.instr_ready;
    assign slot_free = ~valid | transfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr_q <= 8'h00;
            pcq     <= 8'h00;
            valid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
            pcq     <= pcq_nxt;
            valid   <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_q;
        pcq_nxt   = pcq;
        valid_nxt = valid;
        // A redirect flushes the slot even if decode is accepting this cycle.
        if (bus.branch_valid) begin
            pc_nxt    = bus.branch_target;
            valid_nxt = 1'b0;
            state_nxt = bus.en ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) valid_nxt = 1'b0;
                    if (bus.en)   state_nxt = RUN;
                end
                RUN: begin
                    if (slot_free) begin
                        if (bus.en) begin
                            instr_nxt = bus.imem_instr;
                            pcq_nxt   = pc;
                            valid_nxt = 1'b1;
                            // Halt parks the PC on the halt instruction itself.
                            if (bus.imem_instr == HALT_INSTR) state_nxt = HALTED;
                            else                              pc_nxt    = pc + 8'd1;
                        end else begin
                            valid_nxt = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
                HALTED: begin
                    if (transfer) valid_nxt = 1'b0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pcq;
    assign bus.instr_valid = valid;
    assign bus.halted      = (state == HALTED);
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector-table and scoreboard bench for fetch_unit
module tb_fetch_unit;
    typedef struct {
        logic       en;
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        logic       ev;
        logic [7:0] eout;
        logic [7:0] epc;
        logic       eh;
        logic [7:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    vec_t exp_q[$];
    logic [7:0] mem [256];

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(8'h00), .HALT_INSTR(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_instr = mem[bus.imem_addr];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, {7'd0, bus.instr_valid}, 8'h00);
        chk({tag, "_instr"}, bus.instr_out, 8'h00);
        chk({tag, "_pc_out"}, bus.pc_out, 8'h00);
        chk({tag, "_halted"}, {7'd0, bus.halted}, 8'h00);
        chk({tag, "_addr"}, bus.imem_addr, 8'h00);
    endtask

    task automatic add(input logic en, input logic rdy, input logic br, input logic [7:0] tgt,
                       input logic ev, input logic [7:0] eout, input logic [7:0] epc,
                       input logic eh, input logic [7:0] eaddr);
        vec_t v;
        v.en = en; v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.ev = ev; v.eout = eout; v.epc = epc; v.eh = eh; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic run_range(input int lo, input int hi);
        vec_t e;
        for (int i = lo; i <= hi; i++) begin
            bus.en            = vecs[i].en;
            bus.instr_ready   = vecs[i].rdy;
            bus.branch_valid  = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_valid", i), {7'd0, bus.instr_valid}, {7'd0, e.ev});
            chk($sformatf("v%0d_instr", i), bus.instr_out, e.eout);
            chk($sformatf("v%0d_pc_out", i), bus.pc_out, e.epc);
            chk($sformatf("v%0d_halted", i), {7'd0, bus.halted}, {7'd0, e.eh});
            chk($sformatf("v%0d_addr", i), bus.imem_addr, e.eaddr);
        end
        bus.branch_valid = 1'b0;
    endtask

    // Pulse rst between edges, then hold it across an edge with hostile inputs.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset({tag, "_async"});
        bus.en            = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'h55;
        bus.instr_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset({tag, "_held"});
        rst              = 1'b0;
        bus.branch_valid = 1'b0;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h12; mem[1] = 8'h23; mem[2] = 8'h19; mem[3] = 8'hFF;

        //  en rdy br tgt    ev eout   epc    eh eaddr
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00);   // 0 idle cycle
        add(1, 1, 0, 8'h00, 1, 8'h12, 8'h00, 0, 8'h01);
        add(1, 1, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);
        add(1, 1, 0, 8'h00, 1, 8'h19, 8'h02, 0, 8'h03);
        add(1, 1, 0, 8'h00, 1, 8'hFF, 8'h03, 1, 8'h03);   // 4 halt fetched
        add(1, 1, 0, 8'h00, 0, 8'hFF, 8'h03, 1, 8'h03);
        add(1, 1, 0, 8'h00, 0, 8'hFF, 8'h03, 1, 8'h03);
        add(1, 1, 1, 8'h01, 0, 8'hFF, 8'h03, 0, 8'h01);   // 7 branch out of halt
        add(1, 1, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);
        add(1, 0, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);   // 9 backpressure x3
        add(1, 0, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);
        add(1, 0, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);
        add(1, 1, 0, 8'h00, 1, 8'h19, 8'h02, 0, 8'h03);
        add(1, 0, 1, 8'hFF, 0, 8'h19, 8'h02, 0, 8'hFF);   // 13 flush while stalled
        add(1, 0, 0, 8'h00, 1, 8'h00, 8'hFF, 0, 8'h00);   // 14 pc wraps
        add(1, 1, 0, 8'h00, 1, 8'h12, 8'h00, 0, 8'h01);
        add(0, 1, 0, 8'h00, 0, 8'h12, 8'h00, 0, 8'h01);   // 16 en drop
        add(0, 1, 0, 8'h00, 0, 8'h12, 8'h00, 0, 8'h01);
        add(1, 1, 0, 8'h00, 0, 8'h12, 8'h00, 0, 8'h01);
        add(1, 1, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);
        add(1, 1, 0, 8'h00, 1, 8'h19, 8'h02, 0, 8'h03);
        add(1, 0, 0, 8'h00, 1, 8'h19, 8'h02, 0, 8'h03);   // 21 stall at pc_out 02
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00);   // 22 after reset
        add(1, 1, 0, 8'h00, 1, 8'h12, 8'h00, 0, 8'h01);
        add(1, 1, 0, 8'h00, 1, 8'h23, 8'h01, 0, 8'h02);
        add(1, 1, 0, 8'h00, 1, 8'h19, 8'h02, 0, 8'h03);
        add(1, 1, 0, 8'h00, 1, 8'hFF, 8'h03, 1, 8'h03);
        add(1, 0, 0, 8'h00, 1, 8'hFF, 8'h03, 1, 8'h03);   // 27 halted, pending held
        add(1, 0, 0, 8'h00, 1, 8'hFF, 8'h03, 1, 8'h03);
        add(1, 1, 0, 8'h00, 0, 8'hFF, 8'h03, 1, 8'h03);
        add(1, 1, 1, 8'h03, 0, 8'hFF, 8'h03, 0, 8'h03);   // 30 branch onto halt addr
        add(1, 1, 0, 8'h00, 1, 8'hFF, 8'h03, 1, 8'h03);
        add(1, 0, 0, 8'h00, 1, 8'hFF, 8'h03, 1, 8'h03);   // 32 reset mid-halt follows
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00);
        add(1, 1, 0, 8'h00, 1, 8'h12, 8'h00, 0, 8'h01);

        rst               = 1'b0;
        bus.en            = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        #1 rst = 1'b1;
        #1 check_reset("por");
        bus.en            = 1'b1;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'hAA;
        @(negedge clk);
        check_reset("por_held");
        rst              = 1'b0;
        bus.branch_valid = 1'b0;

        run_range(0, 21);
        async_reset("stall_rst");
        run_range(22, 32);
        async_reset("halt_rst");
        run_range(33, 34);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
